// File: rtl/mul_hilo_ctrl.sv
// Multi-cycle sequencer for the EX-stage 32x32 multiplier: registers operands onto an
// external combinational multiplier, holds the pipeline, then issues one HI/LO write.
module mul_hilo_ctrl #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush,
    input  logic        stall_i,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign,
    input  logic [63:0] mul_result,
    output logic        stall_o,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MADD  = 2'b10;
    localparam logic [1:0] OP_MSUB  = 2'b11;
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic [1:0]  op_q;
    logic [63:0] acc;
    logic [63:0] result;

    // Accumulation wraps modulo 2^64; the multiplier already returns the signed or unsigned product.
    always_comb begin
        result = mul_result;
        case (op_q)
            OP_MADD: result = acc + mul_result;
            OP_MSUB: result = acc - mul_result;
            default: result = mul_result;
        endcase
    end

    // stall_o in IDLE must rise in the same cycle EX presents the instruction.
    assign stall_o = ((state == IDLE) && start && !flush) || ((state == BUSY) && !flush);
    assign hilo_we = (state == DONE) && !stall_i && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            op_q     <= 2'd0;
            acc      <= 64'd0;
            mul_a    <= 32'd0;
            mul_b    <= 32'd0;
            mul_sign <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mul_a    <= src_a;
                        mul_b    <= src_b;
                        mul_sign <= (op != OP_MULTU);
                        op_q     <= op;
                        acc      <= {hi_i, lo_i};
                        cnt      <= CNT_INIT;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        {hi_o, lo_o} <= result;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl: three instances (LATENCY 2, 1, 4) share stimulus,
// each driving its own behavioural combinational multiplier.
module tb_mul_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, flush, stall_i;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, hi_i, lo_i;

    logic [31:0] mul_a2, mul_b2, hi_o2, lo_o2;
    logic        mul_sign2, stall_o2, hilo_we2;
    logic [63:0] mul_result2;
    logic [31:0] mul_a1, mul_b1, hi_o1, lo_o1;
    logic        mul_sign1, stall_o1, hilo_we1;
    logic [63:0] mul_result1;
    logic [31:0] mul_a4, mul_b4, hi_o4, lo_o4;
    logic        mul_sign4, stall_o4, hilo_we4;
    logic [63:0] mul_result4;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    assign mul_result2 = mul_model(mul_a2, mul_b2, mul_sign2);
    assign mul_result1 = mul_model(mul_a1, mul_b1, mul_sign1);
    assign mul_result4 = mul_model(mul_a4, mul_b4, mul_sign4);

    mul_hilo_ctrl #(.LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_i(hi_i), .lo_i(lo_i), .flush(flush), .stall_i(stall_i),
        .mul_a(mul_a2), .mul_b(mul_b2), .mul_sign(mul_sign2), .mul_result(mul_result2),
        .stall_o(stall_o2), .hilo_we(hilo_we2), .hi_o(hi_o2), .lo_o(lo_o2));

    mul_hilo_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_i(hi_i), .lo_i(lo_i), .flush(flush), .stall_i(stall_i),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_sign(mul_sign1), .mul_result(mul_result1),
        .stall_o(stall_o1), .hilo_we(hilo_we1), .hi_o(hi_o1), .lo_o(lo_o1));

    mul_hilo_ctrl #(.LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_i(hi_i), .lo_i(lo_i), .flush(flush), .stall_i(stall_i),
        .mul_a(mul_a4), .mul_b(mul_b4), .mul_sign(mul_sign4), .mul_result(mul_result4),
        .stall_o(stall_o4), .hilo_we(hilo_we4), .hi_o(hi_o4), .lo_o(lo_o4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full operation on the LATENCY=2 instance; operands are scrambled once BUSY begins.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                          input logic [63:0] exp);
        int stalls;
        int n;
        op = o; src_a = a; src_b = b; hi_i = h; lo_i = l; start = 1'b1;
        #1;
        stalls = 0;
        n = 0;
        while (stall_o2 === 1'b1 && n < 20) begin
            stalls++;
            n++;
            tick();
            start = 1'b0; src_a = ~a; src_b = ~b; hi_i = ~h; lo_i = ~l;
            #1;
            if (n == 1) begin
                check({tag, ".mul_ab"}, {mul_a2, mul_b2}, {a, b});
                check({tag, ".mul_sign"}, 64'(mul_sign2), 64'(o != 2'b01));
            end
        end
        check({tag, ".stall_len"}, 64'(stalls), 64'd3);
        check({tag, ".we"}, 64'(hilo_we2), 64'd1);
        check({tag, ".hilo"}, {hi_o2, lo_o2}, exp);
        tick();
        check({tag, ".we_once"}, 64'(hilo_we2), 64'd0);
        repeat (3) tick();
    endtask

    initial begin
        int s1, s4, w1, w4;
        logic [63:0] r1, r4;

        rst = 1'b1; start = 1'b0; flush = 1'b0; stall_i = 1'b0; op = 2'b00;
        src_a = 32'd0; src_b = 32'd0; hi_i = 32'd0; lo_i = 32'd0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("reset.stall_o", 64'(stall_o2), 64'd0);
        check("reset.hilo_we", 64'(hilo_we2), 64'd0);
        check("reset.mul_ab", {mul_a2, mul_b2}, 64'd0);
        check("reset.mul_sign", 64'(mul_sign2), 64'd0);
        check("reset.hilo", {hi_o2, lo_o2}, 64'd0);

        run_op("mult_neg", 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFE);
        run_op("multu_big", 2'b01, 32'hFFFFFFFF, 32'h00000002, 32'd0, 32'd0, 64'h00000001_FFFFFFFE);
        run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 64'h40000000_00000000);
        run_op("multu_min", 2'b01, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 64'h40000000_00000000);
        run_op("madd", 2'b10, 32'd3, 32'hFFFFFFFE, 32'd0, 32'd5, 64'hFFFFFFFF_FFFFFFFF);
        run_op("msub_wrap", 2'b11, 32'd1, 32'd1, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFF);
        run_op("msub_borrow", 2'b11, 32'd1, 32'd1, 32'd1, 32'd0, 64'h00000000_FFFFFFFF);

        // Flush in the second BUSY cycle, then a fresh start right after
        op = 2'b00; src_a = 32'd5; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        check("flush.stall_o", 64'(stall_o2), 64'd0);
        check("flush.we", 64'(hilo_we2), 64'd0);
        check("flush.we_lat1", 64'(hilo_we1), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush.idle_stall", 64'(stall_o2), 64'd0);
        check("flush.idle_we", 64'(hilo_we2), 64'd0);
        check("flush.hilo_held", {hi_o2, lo_o2}, 64'h00000000_FFFFFFFF);
        run_op("after_flush", 2'b01, 32'd7, 32'd6, 32'd0, 32'd0, 64'd42);

        // Downstream stall holds DONE for three cycles
        op = 2'b00; src_a = 32'h00010000; src_b = 32'h00010000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_i.we", 64'(hilo_we2), 64'd0);
            check("stall_i.hilo", {hi_o2, lo_o2}, 64'h00000001_00000000);
            tick();
        end
        stall_i = 1'b0;
        #1;
        check("stall_i.release_we", 64'(hilo_we2), 64'd1);
        check("stall_i.release_stall", 64'(stall_o2), 64'd0);
        tick();
        check("stall_i.after_we", 64'(hilo_we2), 64'd0);
        repeat (5) tick();

        // LATENCY sweep on the 1- and 4-cycle instances
        op = 2'b01; src_a = 32'd9; src_b = 32'd11; hi_i = 32'd0; lo_i = 32'd0; start = 1'b1;
        #1;
        s1 = 0; s4 = 0; w1 = 0; w4 = 0; r1 = '0; r4 = '0;
        for (int c = 0; c < 10; c++) begin
            s1 += int'(stall_o1);
            s4 += int'(stall_o4);
            w1 += int'(hilo_we1);
            w4 += int'(hilo_we4);
            if (hilo_we1) r1 = {hi_o1, lo_o1};
            if (hilo_we4) r4 = {hi_o4, lo_o4};
            tick();
            start = 1'b0;
            #1;
        end
        check("lat1.stall_len", 64'(s1), 64'd2);
        check("lat4.stall_len", 64'(s4), 64'd5);
        check("lat1.we_count", 64'(w1), 64'd1);
        check("lat4.we_count", 64'(w4), 64'd1);
        check("lat1.hilo", r1, 64'd99);
        check("lat4.hilo", r4, 64'd99);

        // Reset in mid-BUSY clears everything
        op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst.stall_o", 64'(stall_o2), 64'd0);
        check("midrst.hilo_we", 64'(hilo_we2), 64'd0);
        check("midrst.mul_ab", {mul_a2, mul_b2}, 64'd0);
        check("midrst.mul_sign", 64'(mul_sign2), 64'd0);
        check("midrst.hilo", {hi_o2, lo_o2}, 64'd0);
        repeat (4) tick();
        check("midrst.no_we", 64'(hilo_we2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Multi-cycle sequencer for the EX-stage 32x32 multiplier in the CPU core. It accepts MULT/MULTU/MADD/MSUB requests from EX and registers the operands onto the external combinational multiplier's ports. It holds the pipeline for a fixed number of cycles so the multiplier path can be multicycle-constrained, then applies HI/LO accumulation and issues a single HI/LO write.

## Interface
- LATENCY, 2, BUSY cycles the multiplier inputs are held stable before the product is sampled; legal 1..4
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a valid mult-class instruction
- op  in  2  00 MULT (signed), 01 MULTU, 10 MADD (signed), 11 MSUB (signed)
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- hi_i  in  32  current (forwarded) HI
- lo_i  in  32  current (forwarded) LO
- flush  in  1  exception/ERET flush of EX
- stall_i  in  1  downstream pipeline stall
- mul_a  out  32  registered multiplier operand a
- mul_b  out  32  registered multiplier operand b
- mul_sign  out  1  registered signed-mode select, 1 for op != 01
- mul_result  in  64  combinational product from multiplier
- stall_o  out  1  hold IF..EX
- hilo_we  out  1  one-shot HI/LO write enable
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data

## Operation
- States: IDLE, BUSY, DONE. Down-counter cnt holds the BUSY cycles remaining.
- IDLE:
  - stall_o = start & ~flush.
  - On start & ~flush: latch src_a/src_b into mul_a/mul_b, set mul_sign, latch op, latch {hi_i,lo_i} into acc, load cnt = LATENCY-1, go to BUSY.
- BUSY:
  - stall_o = 1; mul_* are held constant.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: capture the result into {hi_o,lo_o} and go to DONE.
    - MULT/MULTU: result = mul_result.
    - MADD: result = acc + mul_result.
    - MSUB: result = acc - mul_result.
    - All accumulate arithmetic is 64-bit modulo 2^64; no saturation and no overflow flag.
- DONE:
  - stall_o = 0.
  - hilo_we = ~stall_i & ~flush.
  - If stall_i: stay in DONE with hi_o/lo_o held, so the write issues exactly once.
  - Else: go to IDLE.
- start is ignored in BUSY and DONE; operands are never re-sampled mid-operation.
- flush in any state: next state IDLE, cnt cleared, hilo_we = 0 and stall_o = 0 in the flush cycle; hi_o/lo_o hold their last values.
- rst takes priority over flush.
- stall_i has no effect in IDLE or BUSY; only the DONE exit is gated by it.
- The block has no internal HI/LO storage; the HI/LO register file consumes hilo_we/hi_o/lo_o.

## Timing
- Reset (rst high at an edge): state IDLE; cnt, mul_a, mul_b, mul_sign, hi_o, lo_o, hilo_we, stall_o all 0.
- start in IDLE at cycle T: stall_o high in T. Operands appear on mul_* from T+1.
- BUSY spans T+1..T+LATENCY; the product is sampled at the end of T+LATENCY.
- DONE at T+LATENCY+1: hilo_we = 1, stall_o = 0, instruction leaves EX.
- Total stall is LATENCY+1 cycles; hi_o/lo_o are valid at the first DONE cycle.
- Back-to-back mult instructions: the second start is accepted at T+LATENCY+2 at the earliest, since the block is in IDLE again.
- hilo_we, stall_o and mul_sign are single-bit; no X may propagate from reset.

## Test plan
- MULT, LATENCY=2, a=0xFFFFFFFF, b=0x00000002 -> stall_o high for 3 cycles, then hilo_we for 1 cycle with hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE. The same operands with MULTU -> hi_o=0x00000001, lo_o=0xFFFFFFFE.
- MULT a=b=0x80000000 -> hi_o=0x40000000, lo_o=0x00000000. MULTU with the same operands gives the same values.
- MADD hi_i=0, lo_i=5, a=3, b=0xFFFFFFFE -> hi_o=lo_o=0xFFFFFFFF.
- MSUB hi_i=lo_i=0, a=b=1 -> hi_o=lo_o=0xFFFFFFFF.
- MSUB hi_i=0x00000001, lo_i=0, a=b=1 -> hi_o=0x00000000, lo_o=0xFFFFFFFF.
- flush asserted in the 2nd BUSY cycle -> IDLE next cycle, hilo_we never asserted, stall_o low from the flush cycle. A fresh start in the following cycle is accepted normally.
- stall_i held high for 3 cycles on entry to DONE -> hilo_we stays 0 and hi_o/lo_o stay stable. When stall_i drops, exactly one hilo_we pulse, then IDLE.
- rst in mid-BUSY -> all outputs 0 next cycle.
- Sweep LATENCY=1 and 4 -> stall length 2 and 5 cycles respectively.
